sr_cmd_gen: RTL

//   Upstream command stage for the sr_1 SR latch. Synchronises and debounces two raw

---
 rtl/sr_cmd_gen_if.sv | 19 +
 rtl/sr_cmd_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and latch command outputs of the SR command generator.
interface sr_cmd_gen_if;
  logic BtnS;
  logic BtnR;
  logic S;
  logic R;
  logic Err;
  logic Busy;

  modport master (
    output BtnS, BtnR,
    input  S, R, Err, Busy
  );

  modport slave (
    input  BtnS, BtnR,
    output S, R, Err, Busy
  );
endinterface

// File: rtl/sr_cmd_gen.sv
// Debounced push-button to one-shot S/R pulse generator for an SR latch.
// S and R never overlap; conflicting presses raise a one-cycle Err.
module sr_cmd_gen #(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input logic         clk,
  input logic         rst,
  sr_cmd_gen_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int PMAX = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int PW = $clog2(PMAX) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PUL_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SET,
    RST,
    GAP
  } state_t;

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    press;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_n;
  logic          err_n;

  // Channel 0 is the set button, channel 1 the reset button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= {bus.BtnR, bus.BtnS};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (press[0] && press[1]) begin
          err_n = 1'b1;
        end else if (press[0]) begin
          if (deb[1]) err_n = 1'b1;
          else state_n = SET;
        end else if (press[1]) begin
          if (deb[0]) err_n = 1'b1;
          else state_n = RST;
        end
      end
      SET, RST: begin
        if (cnt == PUL_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.S    <= 1'b0;
      bus.R    <= 1'b0;
      bus.Err  <= 1'b0;
      bus.Busy <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bus.S    <= (state_n == SET);
      bus.R    <= (state_n == RST);
      bus.Err  <= err_n;
      bus.Busy <= (state_n != IDLE);
    end
  end

endmodule
